mealy_seq_detector_param: RTL and testbench
===========================================

Name: mealy_seq_detector_param

Overview:
Parametrised, runtime-programmable Mealy serial sequence detector. It generalises the fixed 4-bit overlapping pattern detector to any pattern length. The pattern can be reloaded at run time, overlap/non-overlap mode is selectable per cycle, input is qualified by a valid strobe, and a saturating detection counter is provided. It sits on a 1-bit serial data stream and flags a match in the same cycle as the final matching bit arrives.

Parameters:
PATTERN_LEN, 4, pattern length in bits; legal range 2..32.
PATTERN, 4'b1010, reset-time pattern, PATTERN_LEN bits wide; bit [PATTERN_LEN-1] is the first bit received.
COUNT_W, 8, width of the detection counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous active-high reset.
en  in  1  data-valid; data is sampled only when en=1.
data  in  1  serial input bit.
overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping.
pat_load  in  1  load pat_in as the new pattern on this edge.
pat_in  in  PATTERN_LEN  new pattern value (MSB is the first bit).
detected  out  1  Mealy match flag, combinational.
det_count  out  COUNT_W  number of detections, saturating.
pattern_q  out  PATTERN_LEN  currently active pattern.

Behaviour:
- State elements:
  - pat_q: PATTERN_LEN bits.
  - hist: shift register of the last PATTERN_LEN-1 accepted bits; newest bit is in the LSB.
  - fill: valid-history count, range 0..PATTERN_LEN-1.
  - cnt: COUNT_W bits.
- Reset (rst=1 at an edge): pat_q<=PATTERN, hist<=0, fill<=0, cnt<=0.
  - detected is forced 0 while rst=1.
  - Reset mid-sequence discards all partial history.
- detected = !rst && en && !pat_load && fill==PATTERN_LEN-1 && {hist,data}==pat_q.
  - Purely combinational from the current data bit. Zero latency: it asserts in the cycle the last pattern bit is presented.
- Edge with en=1, pat_load=0, no match: hist<={hist[PATTERN_LEN-3:0],data}; fill<=min(fill+1,PATTERN_LEN-1).
- Edge with en=1, pat_load=0, match:
  - overlap_en=1: shift exactly as above, so the history is retained and the pattern suffix can begin a new match.
  - overlap_en=0: hist<=0, fill<=0. The next match needs PATTERN_LEN fresh bits.
  - overlap_en is sampled in the match cycle only; changing it mid-stream does not alter history already accepted.
- Edge with en=0: hist, fill and cnt hold; detected=0. Gaps in en do not break a partial match.
- pat_load=1 (rst=0): pat_q<=pat_in, hist<=0, fill<=0, cnt unchanged.
  - If en=1 in the same cycle, load wins: the data bit is discarded and detected=0.
  - pattern_q reflects the new pattern from the next cycle.
- Counter: cnt increments by 1 on every edge where detected=1. It holds at 2^COUNT_W-1 and never wraps.
  - det_count=cnt (registered), so it updates the cycle after detected.
- Priority at an edge: rst > pat_load > en.
- Any pat_q value is legal, including all-0 and all-1. For all-1 with overlap, every accepted bit after the first PATTERN_LEN-1 ones matches.
- Implementation note: explicit FSM encoding is not required. The fill/hist shift structure defines the state. Overlap correctness comes from retaining the full history, not from a precomputed failure table.

Test Plan:
- Overlap, default 1010, overlap_en=1, en=1, stream 1,0,1,0,1,0,1,0 after reset -> detected=1 on bits 4, 6 and 8; det_count=3 one cycle after bit 8.
- Non-overlap: same stream with overlap_en=0 -> detected=1 on bits 4 and 8 only; det_count=2.
- en gaps: stream 1,0,(en=0 for 3 cycles, data toggling),1,0 -> detected=1 only on the final 0; no assertion during the gap.
- Runtime reload: pat_load=1 with pat_in=4'b0110 while en=1, then stream 0,1,1,0,1,1,0 with overlap on -> the bit presented in the load cycle is ignored; detected=1 on bits 4 and 7; pattern_q=0110; det_count keeps its prior value plus 2.
- Reset mid-operation: feed 1,0,1, assert rst for one cycle, then feed 0 -> no detection; after reset det_count=0 and pattern_q=1010.
- Saturation: COUNT_W=2, overlap on, feed 10 repeated 6 times (5 overlapping detections) -> det_count reaches 3 and stays 3; detected still pulses for every match.

Source files
------------

// File: rtl/mealy_seq_detector_param.sv
// Runtime-programmable Mealy serial sequence detector.
//
// This block watches a 1-bit serial stream that is qualified by en. It raises
// detected combinationally in the same cycle that the final bit of the active
// pattern arrives. The pattern can be reloaded at run time. Overlapping and
// non-overlapping detection are selectable on every cycle. A saturating
// counter records the number of detections.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   en         data-valid; data is sampled only when en=1
//   data       serial input bit
//   overlap_en 1 = overlapping detection, 0 = non-overlapping
//   pat_load   load pat_in as the new pattern on this edge
//   pat_in     new pattern value (MSB is the first bit received)
//   detected   Mealy match flag (combinational)
//   det_count  saturating detection count (registered)
//   pattern_q  currently active pattern
module mealy_seq_detector_param #(
  parameter int unsigned                PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0]     PATTERN     = 4'b1010,
  parameter int unsigned                COUNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   data,
  input  logic                   overlap_en,
  input  logic                   pat_load,
  input  logic [PATTERN_LEN-1:0] pat_in,
  output logic                   detected,
  output logic [COUNT_W-1:0]     det_count,
  output logic [PATTERN_LEN-1:0] pattern_q
);

  localparam int unsigned HW     = PATTERN_LEN - 1;
  localparam int unsigned FILL_W = $clog2(PATTERN_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_LEN - 1);

  logic [PATTERN_LEN-1:0] pat_q, pat_d;
  logic [HW-1:0]          hist, hist_d;
  logic [FILL_W-1:0]      fill, fill_d;
  logic [COUNT_W-1:0]     cnt, cnt_d;

  logic [PATTERN_LEN-1:0] window;
  logic                   full;
  logic                   match;

  always_comb begin
    // The candidate window is the accepted history with the current bit
    // appended. Slicing this window gives the shifted history without a
    // hist[HW-2:0] select, which would be an invalid range when PATTERN_LEN=2.
    window   = {hist, data};
    full     = (fill == FILL_MAX);
    match    = full && (window == pat_q);
    detected = !rst && en && !pat_load && match;

    pat_d  = pat_q;
    hist_d = hist;
    fill_d = fill;
    cnt_d  = cnt;

    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      if (detected && !overlap_en) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[HW-1:0];
        if (!full) begin
          fill_d = fill + 1'b1;
        end
      end
      if (detected && (cnt != '1)) begin
        cnt_d = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= PATTERN;
      hist  <= '0;
      fill  <= '0;
      cnt   <= '0;
    end else begin
      pat_q <= pat_d;
      hist  <= hist_d;
      fill  <= fill_d;
      cnt   <= cnt_d;
    end
  end

  assign det_count = cnt;
  assign pattern_q = pat_q;

endmodule

// File: tb/tb_mealy_seq_detector_param.sv
module tb_mealy_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst, en, data, overlap_en, pat_load;
  logic [3:0] pat_in;

  logic       det_a, det_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [3:0] pq_a, pq_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Default configuration.
  mealy_seq_detector_param #(
    .PATTERN_LEN(4), .PATTERN(4'b1010), .COUNT_W(8)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .data(data), .overlap_en(overlap_en),
    .pat_load(pat_load), .pat_in(pat_in),
    .detected(det_a), .det_count(cnt_a), .pattern_q(pq_a)
  );

  // Narrow counter used to exercise saturation.
  mealy_seq_detector_param #(
    .PATTERN_LEN(4), .PATTERN(4'b1010), .COUNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .data(data), .overlap_en(overlap_en),
    .pat_load(pat_load), .pat_in(pat_in),
    .detected(det_b), .det_count(cnt_b), .pattern_q(pq_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one bit for one cycle. Check detected before the edge, then step
  // to just after the edge.
  task automatic bit_in(input logic d, input logic e, input logic exp_det);
    data = d;
    en   = e;
    @(negedge clk);
    chk("detected_a", det_a, exp_det);
    chk("detected_b", det_b, exp_det);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en   = 1'b1;
    data = 1'b0;
    @(negedge clk);
    chk("det_in_rst", det_a, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b0;
  endtask

  logic [7:0] s8;

  initial begin
    rst = 1'b1; en = 1'b0; data = 1'b0; overlap_en = 1'b1;
    pat_load = 1'b0; pat_in = 4'b0000;
    @(posedge clk); #1;

    // Reset state
    do_reset();
    chk("rst_count", cnt_a, 8'd0);
    chk("rst_pattern", pq_a, 4'b1010);

    // Overlapping detection of 1010 within 10101010
    overlap_en = 1'b1;
    s8 = 8'b10101010;
    for (int i = 7; i >= 0; i--)
      bit_in(s8[i], 1'b1, (i == 4) || (i == 2) || (i == 0));
    chk("ovl_count", cnt_a, 8'd3);

    // Non-overlapping detection on the same stream
    do_reset();
    overlap_en = 1'b0;
    for (int i = 7; i >= 0; i--)
      bit_in(s8[i], 1'b1, (i == 4) || (i == 0));
    chk("novl_count", cnt_a, 8'd2);

    // Gaps in en keep partial history; no detection during the gap
    do_reset();
    overlap_en = 1'b1;
    bit_in(1'b1, 1'b1, 1'b0);
    bit_in(1'b0, 1'b1, 1'b0);
    bit_in(1'b1, 1'b0, 1'b0);
    bit_in(1'b0, 1'b0, 1'b0);
    bit_in(1'b1, 1'b0, 1'b0);
    bit_in(1'b1, 1'b1, 1'b0);
    bit_in(1'b0, 1'b1, 1'b1);
    chk("gap_count", cnt_a, 8'd1);

    // Runtime reload while en=1: load wins and the bit is discarded
    pat_in   = 4'b0110;
    pat_load = 1'b1;
    data     = 1'b0;
    en       = 1'b1;
    @(negedge clk);
    chk("load_det", det_a, 1'b0);
    chk("load_old_pat", pq_a, 4'b1010);
    @(posedge clk); #1;
    pat_load = 1'b0;
    chk("load_new_pat", pq_a, 4'b0110);
    chk("load_keep_cnt", cnt_a, 8'd1);
    s8 = 8'b0110110_0;
    for (int i = 7; i >= 1; i--)
      bit_in(s8[i], 1'b1, (i == 4) || (i == 1));
    chk("reload_count", cnt_a, 8'd3);

    // Mid-sequence reset discards history
    pat_in = 4'b1010; pat_load = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    pat_load = 1'b0;
    chk("reload2_cnt", cnt_a, 8'd3);
    bit_in(1'b1, 1'b1, 1'b0);
    bit_in(1'b0, 1'b1, 1'b0);
    bit_in(1'b1, 1'b1, 1'b0);
    do_reset();
    bit_in(1'b0, 1'b1, 1'b0);
    chk("midrst_count", cnt_a, 8'd0);
    chk("midrst_pattern", pq_a, 4'b1010);

    // All-ones pattern with overlap: every bit after the first three matches
    pat_in = 4'b1111; pat_load = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    pat_load = 1'b0;
    for (int i = 0; i < 6; i++)
      bit_in(1'b1, 1'b1, i >= 3);
    chk("ones_count", cnt_a, 8'd3);
    do_reset();
    chk("ones_rst_pat", pq_a, 4'b1010);

    // Saturation: five overlapping detections, 2-bit counter saturates at 3
    overlap_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bit_in((i % 2) == 0, 1'b1, (i >= 3) && ((i % 2) == 1));
      if (i == 7) chk("sat_mid", cnt_b, 2'd3);
    end
    chk("sat_count_b", cnt_b, 2'd3);
    chk("sat_count_a", cnt_a, 8'd5);
    chk("sat_pattern_b", pq_b, 4'b1010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
